i4003_chain: RTL and testbench

- Parametrised successor to the single 10-bit i4003 shift register used in the MCS-4 system top.
- Models STAGES cascaded shift registers of WIDTH bits each, in the sysclk domain.
- The shift clock (cp, typically clk2 or a RAM output-port bit) is sampled and edge-detected rather than used as a clock.
- Adds a bit counter and a frame-complete pulse so the system can tell when a full word has been shifted out of a 4002 output port.

---
 rtl/i4003_chain.sv | 108 ++++++++++
 tb/tb_i4003_chain.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i4003_chain.sv
// i4003_chain: STAGES cascaded WIDTH-bit i4003-style shift registers, all in
// the sysclk domain. The shift clock is sampled and edge-detected, so a rising
// edge on i_cp causes exactly one shift.
//
// Optional feature: define I4003_CHAIN_LATCH_EN to add an output latch. The
// latch is loaded from the shift register on a rising edge of i_strobe, and
// o_parallel_out then shows the latch instead of the live register.
//
// Ports:
//   i_sysclk       system clock (only clock)
//   i_reset        synchronous, active-high reset
//   i_cp           shift clock, sampled; rising edge = one shift
//   i_serial_in    bit shifted into position 0
//   i_enable       output enable; low forces o_parallel_out to 0
//   i_strobe       (I4003_CHAIN_LATCH_EN only) latch strobe, edge-detected
//   o_parallel_out registered parallel view (N = WIDTH*STAGES bits)
//   o_serial_out   top bit of the chain, sr[N-1]
//   o_bit_count    shifts taken modulo N
//   o_frame_done   one-cycle pulse after the Nth shift of a frame
module i4003_chain #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 1,
    parameter int CNT_W  = ($clog2(WIDTH*STAGES) < 1) ? 1 : $clog2(WIDTH*STAGES)
) (
    input  logic                    i_sysclk,
    input  logic                    i_reset,
    input  logic                    i_cp,
    input  logic                    i_serial_in,
    input  logic                    i_enable,
`ifdef I4003_CHAIN_LATCH_EN
    input  logic                    i_strobe,
`endif
    output logic [WIDTH*STAGES-1:0] o_parallel_out,
    output logic                    o_serial_out,
    output logic [CNT_W-1:0]        o_bit_count,
    output logic                    o_frame_done
);
    localparam int               N    = WIDTH * STAGES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic             r_cp_q;
    logic [N-1:0]     r_sr;
    logic [N-1:0]     r_po;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fd;

    logic             w_shift_ev;
    logic             w_last;
    logic [N-1:0]     w_po_src;

    assign w_shift_ev = i_cp & ~r_cp_q;
    assign w_last     = (r_cnt == LAST);

    // The edge detector keeps sampling through reset so that a shift clock
    // already high at reset release is not mistaken for a fresh edge.
    always_ff @(posedge i_sysclk) begin
        r_cp_q <= i_cp;
    end

`ifdef I4003_CHAIN_LATCH_EN
    logic         r_strobe_q;
    logic [N-1:0] r_lt;
    logic         w_strobe_ev;

    assign w_strobe_ev = i_strobe & ~r_strobe_q;

    always_ff @(posedge i_sysclk) begin
        r_strobe_q <= i_strobe;
    end

    // Captures the register value before any coincident shift lands.
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_lt <= '0;
        end else if (w_strobe_ev) begin
            r_lt <= r_sr;
        end
    end

    assign w_po_src = r_lt;
`else
    assign w_po_src = r_sr;
`endif

    // The stages share one N-bit vector, so each stage's top bit feeds the
    // next stage's bit 0 without explicit wiring.
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_fd  <= 1'b0;
            r_po  <= '0;
        end else begin
            if (w_shift_ev) begin
                r_sr  <= {r_sr[N-2:0], i_serial_in};
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            r_fd <= w_shift_ev & w_last;
            r_po <= i_enable ? w_po_src : '0;
        end
    end

    assign o_parallel_out = r_po;
    assign o_serial_out   = r_sr[N-1];
    assign o_bit_count    = r_cnt;
    assign o_frame_done   = r_fd;

endmodule

// File: tb/tb_i4003_chain.sv
module tb_i4003_chain;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cp, sin, en;
`ifdef I4003_CHAIN_LATCH_EN
    logic stb;
`endif

    logic [9:0] po10; logic so10, fd10; logic [3:0] bc10;
    logic [7:0] po8;  logic so8,  fd8;  logic [2:0] bc8;

    i4003_chain #(.WIDTH(10), .STAGES(1)) dut10 (
        .i_sysclk(clk), .i_reset(reset), .i_cp(cp), .i_serial_in(sin), .i_enable(en),
`ifdef I4003_CHAIN_LATCH_EN
        .i_strobe(stb),
`endif
        .o_parallel_out(po10), .o_serial_out(so10), .o_bit_count(bc10), .o_frame_done(fd10)
    );

    i4003_chain #(.WIDTH(4), .STAGES(2)) dut8 (
        .i_sysclk(clk), .i_reset(reset), .i_cp(cp), .i_serial_in(sin), .i_enable(en),
`ifdef I4003_CHAIN_LATCH_EN
        .i_strobe(stb),
`endif
        .o_parallel_out(po8), .o_serial_out(so8), .o_bit_count(bc8), .o_frame_done(fd8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q10[$];
    logic [31:0] q8[$];

    logic [9:0] m_sr10, m_lt10;
    logic [7:0] m_sr8,  m_lt8;
    int         m_cnt10, m_cnt8;
    logic       m_en;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sr10 = '0; m_lt10 = '0; m_cnt10 = 0;
        m_sr8  = '0; m_lt8  = '0; m_cnt8  = 0;
    endtask

    function automatic logic [31:0] exp_po10();
`ifdef I4003_CHAIN_LATCH_EN
        return m_en ? {22'd0, m_lt10} : 32'd0;
`else
        return m_en ? {22'd0, m_sr10} : 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_po8();
`ifdef I4003_CHAIN_LATCH_EN
        return m_en ? {24'd0, m_lt8} : 32'd0;
`else
        return m_en ? {24'd0, m_sr8} : 32'd0;
`endif
    endfunction

    // One model shift (with optional coincident strobe); queues the
    // parallel_out value expected one cycle after the shift edge.
    task automatic model_shift(input logic s, input logic st, output logic e10, output logic e8);
        e10 = (m_cnt10 == 9);
        e8  = (m_cnt8 == 7);
        if (st) begin
            m_lt10 = m_sr10;
            m_lt8  = m_sr8;
        end
        m_sr10  = {m_sr10[8:0], s};
        m_sr8   = {m_sr8[6:0], s};
        m_cnt10 = e10 ? 0 : m_cnt10 + 1;
        m_cnt8  = e8  ? 0 : m_cnt8 + 1;
        q10.push_back(exp_po10());
        q8.push_back(exp_po8());
    endtask

    task automatic pulse(input logic s, input logic st);
        logic e10, e8;
        cp = 1'b1; sin = s;
`ifdef I4003_CHAIN_LATCH_EN
        stb = st;
`endif
        model_shift(s, st, e10, e8);
        tick();
        chk("fd10_edge", {31'd0, fd10}, {31'd0, e10});
        chk("fd8_edge",  {31'd0, fd8},  {31'd0, e8});
        chk("cnt10", {28'd0, bc10}, m_cnt10);
        chk("cnt8",  {29'd0, bc8},  m_cnt8);
        chk("so10", {31'd0, so10}, {31'd0, m_sr10[9]});
        chk("so8",  {31'd0, so8},  {31'd0, m_sr8[7]});
        cp = 1'b0;
`ifdef I4003_CHAIN_LATCH_EN
        stb = 1'b0;
`endif
        tick();
        chk("po10", {22'd0, po10}, q10.pop_front());
        chk("po8",  {24'd0, po8},  q8.pop_front());
        chk("fd10_clear", {31'd0, fd10}, 32'd0);
        chk("fd8_clear",  {31'd0, fd8},  32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; cp = 1'b0;
        tick();
        model_reset();
        chk("rst_po10", {22'd0, po10}, 32'd0);
        chk("rst_cnt10", {28'd0, bc10}, 32'd0);
        chk("rst_fd10", {31'd0, fd10}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic e10, e8;
        reset = 1'b1; cp = 1'b1; sin = 1'b0; en = 1'b1; m_en = 1'b1;
`ifdef I4003_CHAIN_LATCH_EN
        stb = 1'b0;
`endif
        model_reset();

        // Reset with cp high, then release while cp stays high: no shift.
        tick(); tick();
        chk("rst_po10", {22'd0, po10}, 32'd0);
        chk("rst_po8",  {24'd0, po8},  32'd0);
        chk("rst_cnt10", {28'd0, bc10}, 32'd0);
        chk("rst_fd8", {31'd0, fd8}, 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        chk("rel_po10", {22'd0, po10}, 32'd0);
        chk("rel_cnt10", {28'd0, bc10}, 32'd0);
        chk("rel_cnt8", {29'd0, bc8}, 32'd0);
        chk("rel_fd10", {31'd0, fd10}, 32'd0);
        chk("rel_so10", {31'd0, so10}, 32'd0);
        cp = 1'b0;
        tick();

        // Frame 1,0,...,0,1 on 10 pulses.
        for (int i = 0; i < 10; i++) pulse((i == 0) || (i == 9), 1'b0);
`ifndef I4003_CHAIN_LATCH_EN
        chk("frame_po10", {22'd0, po10}, 32'h201);
`endif
        chk("frame_so10", {31'd0, so10}, 32'd1);
        chk("frame_cnt10", {28'd0, bc10}, 32'd0);

        // cp held high for 20 cycles: one shift only.
        do_reset();
        cp = 1'b1; sin = 1'b1;
        model_shift(1'b1, 1'b0, e10, e8);
        repeat (20) tick();
        chk("hold_cnt10", {28'd0, bc10}, 32'd1);
        chk("hold_po10", {22'd0, po10}, q10.pop_front());
        chk("hold_po8",  {24'd0, po8},  q8.pop_front());
`ifndef I4003_CHAIN_LATCH_EN
        chk("hold_po10_const", {22'd0, po10}, 32'h001);
`endif
        cp = 1'b0;
        tick();

        // Enable gating: shifting and counting continue while disabled.
        do_reset();
        for (int i = 0; i < 10; i++) pulse((i == 0) || (i == 9), 1'b0);
        en = 1'b0; m_en = 1'b0;
        tick();
        chk("dis_po10", {22'd0, po10}, 32'd0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0);
        en = 1'b1; m_en = 1'b1;
        tick();
        chk("reen_po10", {22'd0, po10}, exp_po10());
`ifndef I4003_CHAIN_LATCH_EN
        chk("reen_po10_const", {22'd0, po10}, 32'h008);
`endif
        chk("reen_cnt10", {28'd0, bc10}, 32'd3);

        // 4x2 cascade: ones propagate across the stage boundary.
        do_reset();
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
`ifndef I4003_CHAIN_LATCH_EN
        chk("casc_po8", {24'd0, po8}, 32'hFF);
`endif
        chk("casc_so8", {31'd0, so8}, 32'd1);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        chk("casc_mid_cnt8", {29'd0, bc8}, 32'd5);
        reset = 1'b1;
        tick();
        model_reset();
        chk("casc_rst_po8", {24'd0, po8}, 32'd0);
        chk("casc_rst_cnt8", {29'd0, bc8}, 32'd0);
        chk("casc_rst_so8", {31'd0, so8}, 32'd0);
        chk("casc_rst_fd8", {31'd0, fd8}, 32'd0);
        reset = 1'b0;
        tick();

`ifdef I4003_CHAIN_LATCH_EN
        // Strobe coincident with a shift latches the pre-shift value.
        do_reset();
        for (int i = 0; i < 10; i++) pulse((i == 0) || (i == 9), 1'b0);
        pulse(1'b1, 1'b1);
        chk("latch_po10", {22'd0, po10}, 32'h201);
        chk("latch_sr10", {22'd0, dut10.r_sr}, 32'h003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
